mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Parametrised memory-access pipeline stage that sits between EX and WB. It holds one instruction, waits for the data-memory response on a request/response (data_ok) interface, and aligns and sign/zero-extends load data for a configurable data width. It forwards an opaque payload to WB. On a pipeline flush it tracks loads whose requests are still outstanding, so that their late responses are discarded and never consumed by a younger instruction.

## Interface
Parameters:
- DATA_W, 32 — datapath width; legal values 32 or 64.
- PAYLOAD_W, 70 — width of the opaque EX→WB payload (rf_we, waddr, pc, exception fields).
- MAX_OUTSTANDING, 2 — maximum number of flushed-but-unanswered loads tracked; legal range 1..7.

Ports (OFS_W = log2(DATA_W/8)). Clock is clk; reset is synchronous and active-high.
- clk  in  1  — single clock for the whole block.
- reset  in  1  — synchronous, active-high.
- in_valid  in  1  — EX offers an instruction.
- in_allowin  out  1  — stage accepts this cycle.
- in_payload  in  PAYLOAD_W  — passed through unchanged to WB.
- in_is_load  in  1  — instruction is a load.
- in_req_sent  in  1  — EX issued a data request for this instruction.
- in_size  in  2  — access size: 0 byte, 1 half, 2 word, 3 dword.
- in_unsigned  in  1  — zero-extend the load result.
- in_result  in  DATA_W  — ALU result; its low OFS_W bits are the byte offset.
- data_ok  in  1  — one data response this cycle.
- rdata  in  DATA_W  — response data, valid with data_ok.
- out_valid  out  1  — offer to WB.
- out_allowin  in  1  — WB accepts.
- out_payload  out  PAYLOAD_W  — stored payload.
- out_wdata  out  DATA_W  — final writeback value.
- fwd_pending  out  1  — a load is held and its data has not yet returned; ID must stall consumers.
- flush  in  1  — exception/ertn flush; kills the held instruction.

## Operation
- Stage register (valid, payload, load controls, result) loads when in_valid & in_allowin & ~flush. When in_allowin is high and nothing is captured, valid clears.
- wait_data = valid & in_req_sent_q & ~captured.
- ready_go = ~wait_data.
- in_allowin = (~valid | ready_go & out_allowin) & (discard_cnt != MAX_OUTSTANDING).
- out_valid = valid & ready_go & ~flush.
- fwd_pending = valid & is_load_q & ~captured.

Response routing:
- If data_ok and discard_cnt > 0, the response is dropped and discard_cnt decrements.
- Otherwise, if data_ok & wait_data, rdata goes to rdata_buf and captured is set.
- A data_ok that matches neither condition is a protocol error; it is ignored.

Flush (highest priority):
- valid clears next cycle and nothing is captured.
- If wait_data is true and data_ok is not being consumed by this stage in the same cycle, discard_cnt increments.
- When an increment and a decrement occur in the same cycle, discard_cnt is unchanged.
- A response arriving in the flush cycle for the held load (discard_cnt == 0) is the load's own response and is dropped; no increment occurs.

captured clears when a new instruction enters, on flush, and on reset.

Load extraction, applied to rdata_buf:
- sh = rdata_buf >> (offset·8).
- Size 0 takes bits [7:0]; size 1 takes [15:0]; size 2 takes [31:0]; size 3 takes the full 64 bits (DATA_W=64 only; treated as size 2 when DATA_W=32).
- The result is sign-extended from its top bit, or zero-extended when in_unsigned. Unsigned word on DATA_W=32 is identical to signed.
- out_wdata is the extracted value for loads and result_q otherwise.

Reset values: valid=0, captured=0, discard_cnt=0, in_allowin=1, out_valid=0, fwd_pending=0. out_payload and out_wdata are don't-care while out_valid=0.

## Timing
- Non-memory instruction: out_valid is asserted the cycle after acceptance; the stage contributes zero added latency.
- Load: out_valid rises the cycle after the data_ok that captures it (data is registered; no combinational rdata→out_wdata path). If data_ok arrives in the acceptance cycle+1, out_valid rises at acceptance+2.
- While out_allowin=0, the captured data and payload hold steady; data_ok is not required again.
- Back-to-back transfers run at one instruction per cycle when ready_go=1 and out_allowin=1.
- Reset mid-wait clears discard_cnt. External memory must also be reset, since pending responses are not tracked across reset.

## Test plan
- ALU op: in_result=0x12345678, in_is_load=0 → out_valid=1 one cycle later with out_wdata=0x12345678 and the payload unchanged.
- ld.b at offset 3, rdata=0x80FF_0000, data_ok 2 cycles after acceptance → out_valid 3 cycles after acceptance with out_wdata=0xFFFFFF80. The same access as ld.bu → 0x00000080.
- DATA_W=64: ld.h at offset 6, rdata=0x8001_0000_0000_0000 → 0xFFFF_FFFF_FFFF_8001. ld.d → the full word.
- Load waiting, out_allowin=0 for 3 cycles after data_ok → out_wdata stable, in_allowin=0, no second capture.
- Flush while waiting → discard_cnt=1. A new load is accepted. The first data_ok (0xDEAD) is dropped; the second data_ok (0x1234) gives out_wdata=0x1234.
- MAX_OUTSTANDING=1: after flush with a pending load, in_allowin=0 until data_ok arrives. Flush coinciding with data_ok → discard_cnt stays 0.

Source files
------------

// File: rtl/mem_access_stage.sv
// EX->WB memory-access stage: holds one instruction, waits for its data response,
// aligns/extends load data, and discards late responses of flushed loads.
module mem_access_stage #(
  parameter int DATA_W          = 32,
  parameter int PAYLOAD_W       = 70,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_allowin,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_is_load,
  input  logic                 in_req_sent,
  input  logic [1:0]           in_size,
  input  logic                 in_unsigned,
  input  logic [DATA_W-1:0]    in_result,
  input  logic                 data_ok,
  input  logic [DATA_W-1:0]    rdata,
  output logic                 out_valid,
  input  logic                 out_allowin,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [DATA_W-1:0]    out_wdata,
  output logic                 fwd_pending,
  input  logic                 flush
);

  localparam int OFS_W = $clog2(DATA_W / 8);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic                 valid;
  logic                 is_load_q;
  logic                 req_sent_q;
  logic                 unsigned_q;
  logic                 captured;
  logic [1:0]           size_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [DATA_W-1:0]    result_q;
  logic [DATA_W-1:0]    rdata_buf;
  logic [CNT_W-1:0]     discard_cnt;

  logic wait_data;
  logic ready_go;
  logic accept;
  logic drop_rsp;
  logic capture_rsp;
  logic flush_inc;

  assign wait_data  = valid & req_sent_q & ~captured;
  assign ready_go   = ~wait_data;
  assign in_allowin = (~valid | (ready_go & out_allowin)) & (discard_cnt != CNT_MAX);
  assign accept     = in_valid & in_allowin & ~flush;
  assign out_valid  = valid & ready_go & ~flush;
  assign fwd_pending = valid & is_load_q & ~captured;

  // Responses owed to flushed loads always come back first, so they take priority.
  assign drop_rsp    = data_ok & (discard_cnt != '0);
  assign capture_rsp = data_ok & wait_data & ~drop_rsp & ~flush;
  // A response landing in the flush cycle with nothing owed is the held load's own.
  assign flush_inc   = flush & wait_data & ~(data_ok & ~drop_rsp);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid       <= 1'b0;
      captured    <= 1'b0;
      discard_cnt <= '0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (in_allowin) begin
        valid <= in_valid;
      end

      if (flush || in_allowin) begin
        captured <= 1'b0;
      end else if (capture_rsp) begin
        captured <= 1'b1;
      end

      case ({flush_inc, drop_rsp})
        2'b10:   discard_cnt <= discard_cnt + 1'b1;
        2'b01:   discard_cnt <= discard_cnt - 1'b1;
        default: discard_cnt <= discard_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      payload_q  <= in_payload;
      is_load_q  <= in_is_load;
      req_sent_q <= in_req_sent;
      size_q     <= in_size;
      unsigned_q <= in_unsigned;
      result_q   <= in_result;
    end
    if (capture_rsp) begin
      rdata_buf <= rdata;
    end
  end

  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] ext;
  logic [6:0]        lsh;

  // Extension by shifting the field to the top and back down (logical or arithmetic).
  always_comb begin
    sh = rdata_buf >> {result_q[OFS_W-1:0], 3'b000};
    case (size_q)
      2'd0:    lsh = 7'(DATA_W - 8);
      2'd1:    lsh = 7'(DATA_W - 16);
      2'd2:    lsh = 7'(DATA_W - 32);
      default: lsh = (DATA_W == 64) ? 7'd0 : 7'(DATA_W - 32);
    endcase
    if (unsigned_q) begin
      ext = (sh << lsh) >> lsh;
    end else begin
      ext = DATA_W'($signed(sh << lsh) >>> lsh);
    end
  end

  assign out_payload = payload_q;
  assign out_wdata   = is_load_q ? ext : result_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: 32-bit default, 64-bit datapath, and MAX_OUTSTANDING=1.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  // Shared stimulus for the two 32-bit instances (a: MAX=2, c: MAX=1)
  logic        in_valid, in_is_load, in_req_sent, in_unsigned;
  logic [69:0] in_payload;
  logic [1:0]  in_size;
  logic [31:0] in_result, rdata;
  logic        data_ok, out_allowin, flush;

  logic        a_in_allowin, a_out_valid, a_fwd_pending;
  logic [69:0] a_out_payload;
  logic [31:0] a_out_wdata;
  logic        c_in_allowin, c_out_valid, c_fwd_pending;
  logic [69:0] c_out_payload;
  logic [31:0] c_out_wdata;

  logic        b_in_valid, b_in_is_load, b_in_req_sent, b_in_unsigned;
  logic [69:0] b_in_payload;
  logic [1:0]  b_in_size;
  logic [63:0] b_in_result, b_rdata;
  logic        b_data_ok, b_out_allowin, b_flush;
  logic        b_in_allowin, b_out_valid, b_fwd_pending;
  logic [69:0] b_out_payload;
  logic [63:0] b_out_wdata;

  int n_assert = 0;
  int n_fail   = 0;

  mem_access_stage #(.DATA_W(32), .PAYLOAD_W(70), .MAX_OUTSTANDING(2)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_allowin(a_in_allowin),
    .in_payload(in_payload), .in_is_load(in_is_load), .in_req_sent(in_req_sent),
    .in_size(in_size), .in_unsigned(in_unsigned), .in_result(in_result),
    .data_ok(data_ok), .rdata(rdata), .out_valid(a_out_valid), .out_allowin(out_allowin),
    .out_payload(a_out_payload), .out_wdata(a_out_wdata), .fwd_pending(a_fwd_pending),
    .flush(flush)
  );

  mem_access_stage #(.DATA_W(32), .PAYLOAD_W(70), .MAX_OUTSTANDING(1)) u_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_allowin(c_in_allowin),
    .in_payload(in_payload), .in_is_load(in_is_load), .in_req_sent(in_req_sent),
    .in_size(in_size), .in_unsigned(in_unsigned), .in_result(in_result),
    .data_ok(data_ok), .rdata(rdata), .out_valid(c_out_valid), .out_allowin(out_allowin),
    .out_payload(c_out_payload), .out_wdata(c_out_wdata), .fwd_pending(c_fwd_pending),
    .flush(flush)
  );

  mem_access_stage #(.DATA_W(64), .PAYLOAD_W(70), .MAX_OUTSTANDING(2)) u_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_allowin(b_in_allowin),
    .in_payload(b_in_payload), .in_is_load(b_in_is_load), .in_req_sent(b_in_req_sent),
    .in_size(b_in_size), .in_unsigned(b_in_unsigned), .in_result(b_in_result),
    .data_ok(b_data_ok), .rdata(b_rdata), .out_valid(b_out_valid), .out_allowin(b_out_allowin),
    .out_payload(b_out_payload), .out_wdata(b_out_wdata), .fwd_pending(b_fwd_pending),
    .flush(b_flush)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_a(input logic [31:0] res, input logic [1:0] size, input logic uns);
    in_valid = 1'b1; in_is_load = 1'b1; in_req_sent = 1'b1;
    in_result = res; in_size = size; in_unsigned = uns;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_b(input string tag, input logic [63:0] ofs, input logic [1:0] size,
                       input logic uns, input logic [63:0] rd, input logic [63:0] exp);
    b_in_valid = 1'b1; b_in_is_load = 1'b1; b_in_req_sent = 1'b1;
    b_in_result = ofs; b_in_size = size; b_in_unsigned = uns;
    tick();
    b_in_valid = 1'b0;
    b_data_ok = 1'b1; b_rdata = rd;
    tick();
    b_data_ok = 1'b0;
    chk({tag, "_valid"}, b_out_valid, 1'b1);
    chk({tag, "_wdata"}, b_out_wdata, exp);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 0; in_is_load = 0; in_req_sent = 0; in_unsigned = 0; in_size = 0;
    in_payload = '0; in_result = '0; rdata = '0; data_ok = 0; out_allowin = 1; flush = 0;
    b_in_valid = 0; b_in_is_load = 0; b_in_req_sent = 0; b_in_unsigned = 0; b_in_size = 0;
    b_in_payload = '0; b_in_result = '0; b_rdata = '0; b_data_ok = 0; b_out_allowin = 1;
    b_flush = 0;
    tick(); tick();
    reset = 1'b0;

    chk("rst_allowin", a_in_allowin, 1'b1);
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_fwd_pending", a_fwd_pending, 1'b0);
    chk("rst_b_allowin", b_in_allowin, 1'b1);
    chk("rst_c_out_valid", c_out_valid, 1'b0);

    // ALU op: zero added latency, payload unchanged
    in_valid = 1; in_is_load = 0; in_req_sent = 0;
    in_result = 32'h1234_5678; in_payload = 70'h2A_1234_5678_9ABC_DEF0;
    tick();
    in_valid = 0;
    chk("alu_valid", a_out_valid, 1'b1);
    chk("alu_wdata", a_out_wdata, 32'h1234_5678);
    chk("alu_payload", a_out_payload, 70'h2A_1234_5678_9ABC_DEF0);
    chk("alu_fwd", a_fwd_pending, 1'b0);
    tick();
    chk("alu_drain", a_out_valid, 1'b0);

    // Back-to-back ALU ops
    in_valid = 1; in_result = 32'h11;
    tick();
    chk("b2b0_valid", a_out_valid, 1'b1);
    chk("b2b0_wdata", a_out_wdata, 32'h11);
    chk("b2b0_allowin", a_in_allowin, 1'b1);
    in_result = 32'h22;
    tick();
    in_valid = 0;
    chk("b2b1_valid", a_out_valid, 1'b1);
    chk("b2b1_wdata", a_out_wdata, 32'h22);
    tick();

    // ld.b offset 3, data_ok two cycles after acceptance
    load_a(32'h1003, 2'd0, 1'b0);
    chk("ldb_wait_valid", a_out_valid, 1'b0);
    chk("ldb_wait_fwd", a_fwd_pending, 1'b1);
    chk("ldb_wait_allowin", a_in_allowin, 1'b0);
    tick();
    chk("ldb_wait2_valid", a_out_valid, 1'b0);
    data_ok = 1; rdata = 32'h80FF_0000;
    tick();
    data_ok = 0;
    chk("ldb_valid", a_out_valid, 1'b1);
    chk("ldb_wdata", a_out_wdata, 32'hFFFF_FF80);
    chk("ldb_fwd", a_fwd_pending, 1'b0);
    tick();
    chk("ldb_drain", a_out_valid, 1'b0);

    // ld.bu, data_ok in acceptance+1
    load_a(32'h1003, 2'd0, 1'b1);
    data_ok = 1; rdata = 32'h80FF_0000;
    tick();
    data_ok = 0;
    chk("ldbu_valid", a_out_valid, 1'b1);
    chk("ldbu_wdata", a_out_wdata, 32'h0000_0080);
    tick();

    // ld.h offset 2 under backpressure; stray data_ok must not recapture
    load_a(32'h2, 2'd1, 1'b0);
    data_ok = 1; rdata = 32'h80FF_0000; out_allowin = 0;
    tick();
    rdata = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", a_out_valid, 1'b1);
      chk("bp_wdata", a_out_wdata, 32'hFFFF_80FF);
      chk("bp_allowin", a_in_allowin, 1'b0);
      tick();
      data_ok = 0;
    end
    out_allowin = 1;
    #1;
    chk("bp_release_allowin", a_in_allowin, 1'b1);
    tick();
    chk("bp_drain", a_out_valid, 1'b0);

    // Flush while waiting, then a new load sees its own response after the stale one
    load_a(32'h0, 2'd2, 1'b0);
    tick();
    flush = 1;
    tick();
    flush = 0;
    chk("fl_cnt", u_a.discard_cnt, 2'd1);
    chk("fl_out_valid", a_out_valid, 1'b0);
    chk("fl_fwd", a_fwd_pending, 1'b0);
    chk("fl_allowin", a_in_allowin, 1'b1);
    chk("fl_c_allowin", c_in_allowin, 1'b0);
    load_a(32'h0, 2'd2, 1'b0);
    data_ok = 1; rdata = 32'h0000_DEAD;
    tick();
    data_ok = 0;
    chk("fl_drop_cnt", u_a.discard_cnt, 2'd0);
    chk("fl_drop_valid", a_out_valid, 1'b0);
    chk("fl_drop_fwd", a_fwd_pending, 1'b1);
    chk("fl_c_allowin_back", c_in_allowin, 1'b1);
    data_ok = 1; rdata = 32'h0000_1234;
    tick();
    data_ok = 0;
    chk("fl_new_valid", a_out_valid, 1'b1);
    chk("fl_new_wdata", a_out_wdata, 32'h0000_1234);
    chk("fl_c_idle", c_out_valid, 1'b0);
    tick();

    // Flush coinciding with the held load's own response: nothing owed
    load_a(32'h0, 2'd2, 1'b0);
    flush = 1; data_ok = 1; rdata = 32'h5555;
    tick();
    flush = 0; data_ok = 0;
    chk("flok_a_cnt", u_a.discard_cnt, 2'd0);
    chk("flok_c_cnt", u_c.discard_cnt, 1'd0);
    chk("flok_c_allowin", c_in_allowin, 1'b1);
    chk("flok_out_valid", a_out_valid, 1'b0);

    // Increment and decrement in the same cycle leave the count unchanged
    load_a(32'h0, 2'd2, 1'b0);
    flush = 1;
    tick();
    flush = 0;
    load_a(32'h0, 2'd2, 1'b0);
    flush = 1; data_ok = 1;
    tick();
    flush = 0; data_ok = 0;
    chk("incdec_a_cnt", u_a.discard_cnt, 2'd1);
    chk("incdec_c_cnt", u_c.discard_cnt, 1'd0);

    // Second outstanding flushed load saturates MAX_OUTSTANDING=2
    load_a(32'h0, 2'd2, 1'b0);
    flush = 1;
    tick();
    flush = 0;
    chk("sat_cnt", u_a.discard_cnt, 2'd2);
    chk("sat_allowin", a_in_allowin, 1'b0);
    data_ok = 1;
    tick();
    chk("sat_dec_allowin", a_in_allowin, 1'b1);
    tick();
    data_ok = 0;
    chk("sat_empty_cnt", u_a.discard_cnt, 2'd0);

    // DATA_W = 64 extraction
    run_b("ldh64",  64'd6, 2'd1, 1'b0, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
    run_b("ldhu64", 64'd6, 2'd1, 1'b1, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001);
    run_b("ldd64",  64'd0, 2'd3, 1'b0, 64'h8001_0000_0000_0000, 64'h8001_0000_0000_0000);
    run_b("ldw64",  64'd4, 2'd2, 1'b0, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_8001_0000);
    run_b("ldwu64", 64'd4, 2'd2, 1'b1, 64'h8001_0000_0000_0000, 64'h0000_0000_8001_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
